// File: rtl/qr_text_pkg.sv
// Shared constants, state encoding and codeword layout for the QR byte-mode
// text encoder and decoder.
package qr_text_pkg;

    localparam int CW_BYTES     = 44;
    localparam int MAX_TEXT_LEN = CW_BYTES - 2;

    localparam logic [3:0] MODE_BYTE_MODE = 4'b0100;
    localparam logic [7:0] PAD_BYTE0      = 8'hEC;
    localparam logic [7:0] PAD_BYTE1      = 8'h11;
    localparam logic [5:0] LAST_BYTE      = 6'(CW_BYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DATA = 3'd1,
        ST_TERM = 3'd2,
        ST_PAD  = 3'd3,
        ST_DONE = 3'd4
    } en_text_state_t;

endpackage

// File: rtl/qr_text_pad_gen.sv
// Alternating 0xEC / 0x11 pad-byte source; restarts at 0xEC on clr and
// steps to the other value on every adv.
module qr_pad_gen
    import qr_text_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       adv,
    output logic [7:0] pad_byte
);

    // Pad byte register: clear has priority over advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pad_byte <= PAD_BYTE0;
        end else if (clr) begin
            pad_byte <= PAD_BYTE0;
        end else if (adv) begin
            pad_byte <= (pad_byte == PAD_BYTE0) ? PAD_BYTE1 : PAD_BYTE0;
        end
    end

endmodule

// File: rtl/en_text.sv
// Byte-mode QR text encoder: mode, count, nibble-shifted payload, terminator
// and (with QR_ENC_PAD_EN defined) alternating pad bytes into a 44-byte codeword.
module en_text
    import qr_text_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [7:0]              text_len,
    input  logic                    jis8_valid,
    input  logic [7:0]              jis8_code,
    output logic                    jis8_ready,
    output logic [CW_BYTES*8-1:0]   codeword,
    output logic                    en_text_valid,
    output logic                    busy,
    output logic                    len_err
);

    en_text_state_t               state_r;
    en_text_state_t               state_nx;
    logic [CW_BYTES-1:0][7:0]     cw_r;
    logic [3:0]                   carry_r;
    logic [5:0]                   ptr_r;
    logic [5:0]                   cnt_r;
    logic [5:0]                   len_r;
    logic                         len_ok_s;
    logic                         start_ok_s;
    logic                         hs_s;
    logic                         last_char_s;

    assign codeword    = cw_r;
    assign len_ok_s    = (text_len <= 8'(MAX_TEXT_LEN));
    assign start_ok_s  = (state_r == ST_IDLE) && start && len_ok_s;
    assign hs_s        = jis8_valid && jis8_ready;
    assign last_char_s = ((cnt_r + 6'd1) == len_r);

`ifdef QR_ENC_PAD_EN
    logic [7:0] pad_byte;

    qr_pad_gen u_pad_gen (
        .clk      (clk),
        .rst      (rst),
        .clr      (start_ok_s),
        .adv      (state_r == ST_PAD),
        .pad_byte (pad_byte)
    );
`endif

    // Next-state decode.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_nx = (text_len == 8'd0) ? ST_TERM : ST_DATA;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (hs_s && last_char_s) begin
                    state_nx = ST_TERM;
                end else begin
                    state_nx = ST_DATA;
                end
            end
`ifdef QR_ENC_PAD_EN
            ST_TERM: begin
                if (ptr_r < LAST_BYTE) begin
                    state_nx = ST_PAD;
                end else begin
                    state_nx = ST_DONE;
                end
            end
            ST_PAD: begin
                if (ptr_r == LAST_BYTE) begin
                    state_nx = ST_DONE;
                end else begin
                    state_nx = ST_PAD;
                end
            end
`else
            ST_TERM: state_nx = ST_DONE;
`endif
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // State, registered status outputs and codeword assembly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            cw_r          <= '0;
            carry_r       <= 4'd0;
            ptr_r         <= 6'd0;
            cnt_r         <= 6'd0;
            len_r         <= 6'd0;
            jis8_ready    <= 1'b0;
            busy          <= 1'b0;
            en_text_valid <= 1'b0;
            len_err       <= 1'b0;
        end else begin
            state_r       <= state_nx;
            busy          <= (state_nx != ST_IDLE);
            jis8_ready    <= (state_nx == ST_DATA);
            en_text_valid <= (state_nx == ST_DONE);
            len_err       <= (state_r == ST_IDLE) && start && !len_ok_s;
            case (state_r)
                ST_IDLE: begin
                    if (start_ok_s) begin
                        len_r   <= text_len[5:0];
                        cw_r    <= {{((CW_BYTES - 1) * 8){1'b0}}, MODE_BYTE_MODE, text_len[7:4]};
                        carry_r <= text_len[3:0];
                        ptr_r   <= 6'd1;
                        cnt_r   <= 6'd0;
                    end
                end
                ST_DATA: begin
                    if (hs_s) begin
                        cw_r[ptr_r] <= {carry_r, jis8_code[7:4]};
                        carry_r     <= jis8_code[3:0];
                        ptr_r       <= ptr_r + 6'd1;
                        cnt_r       <= cnt_r + 6'd1;
                    end
                end
                ST_TERM: begin
                    cw_r[ptr_r] <= {carry_r, 4'b0000};
                    ptr_r       <= ptr_r + 6'd1;
                end
`ifdef QR_ENC_PAD_EN
                ST_PAD: begin
                    cw_r[ptr_r] <= pad_byte;
                    ptr_r       <= ptr_r + 6'd1;
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_en_text.sv
// Self-checking bench for en_text: a stream-level codeword model plus a
// per-cycle compare process, pinned by hand-computed literal bytes.
module tb_en_text;
    import qr_text_pkg::*;

`ifdef QR_ENC_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start = 1'b0;
    logic [7:0]            text_len = 8'd0;
    logic                  jis8_valid = 1'b0;
    logic [7:0]            jis8_code = 8'd0;
    logic                  jis8_ready;
    logic [CW_BYTES*8-1:0] codeword;
    logic                  en_text_valid;
    logic                  busy;
    logic                  len_err;

    en_text dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .text_len      (text_len),
        .jis8_valid    (jis8_valid),
        .jis8_code     (jis8_code),
        .jis8_ready    (jis8_ready),
        .codeword      (codeword),
        .en_text_valid (en_text_valid),
        .busy          (busy),
        .len_err       (len_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // expected-behaviour windows, in units of "cycle following edge number cyc"
    bit   mon_en        = 1'b0;
    int   exp_valid_cyc = -1;
    int   exp_lerr_cyc  = -1;
    int   b_lo = 1, b_hi = 0, r_hi = 0;
    logic [351:0] exp_cw = '0;
    logic [351:0] cw_cap = '0;
    logic [7:0]   chars[$];

    function automatic void chk(input string nm, input logic [351:0] act, input logic [351:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Codeword as a bit stream: mode, count, chars, terminator, then pad to 44 bytes.
    function automatic logic [351:0] model_cw(input logic [7:0] cs[$]);
        logic [3:0]   nib[$];
        logic [7:0]   by[$];
        logic [351:0] r;
        int n;
        int first;
        n = cs.size();
        nib.push_back(4'b0100);
        nib.push_back(4'(n >> 4));
        nib.push_back(4'(n & 15));
        foreach (cs[i]) begin
            nib.push_back(cs[i][7:4]);
            nib.push_back(cs[i][3:0]);
        end
        nib.push_back(4'h0);
        for (int i = 0; i < nib.size(); i += 2) by.push_back({nib[i], nib[i+1]});
        first = by.size();
        while (by.size() < 44)
            by.push_back(PAD_EN ? ((((by.size() - first) % 2) == 0) ? 8'hEC : 8'h11) : 8'h00);
        r = '0;
        foreach (by[k]) r[8*k +: 8] = by[k];
        return r;
    endfunction

    // Receiver-side view: recover the characters and count disagreements.
    function automatic int de_text_errs(input logic [351:0] cw, input logic [7:0] cs[$]);
        int errs;
        int n;
        logic [7:0] c;
        errs = 0;
        n = int'({cw[3:0], cw[15:12]});
        if (cw[7:4] != 4'b0100) errs++;
        if (n != cs.size()) errs++;
        else
            for (int i = 0; i < n; i++) begin
                c = {cw[8*(i+1) +: 4], cw[8*(i+2)+4 +: 4]};
                if (c != cs[i]) errs++;
            end
        return errs;
    endfunction

    function automatic int lat(input int n);
        return PAD_EN ? (44 - n) : 2;
    endfunction

    // Per-cycle compare against the expected windows.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("en_text_valid", 352'(en_text_valid), 352'(cyc == exp_valid_cyc));
            chk("len_err", 352'(len_err), 352'(cyc == exp_lerr_cyc));
            chk("busy", 352'(busy), 352'(cyc >= b_lo && cyc <= b_hi));
            chk("jis8_ready", 352'(jis8_ready), 352'(cyc >= b_lo && cyc <= r_hi));
            if (en_text_valid) begin
                cw_cap = codeword;
                chk("codeword", codeword, exp_cw);
            end
        end
    end

    task automatic encode(input bit rand_gap, input bit poke);
        int  n, idx, guard, s, h;
        bit  acc;
        n = chars.size();
        exp_cw = model_cw(chars);
        @(negedge clk);
        start = 1'b1;
        text_len = 8'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
        s = cyc;
        b_lo = s;
        h = s;
        if (n == 0) begin
            exp_valid_cyc = s + lat(0) - 1;
            b_hi = exp_valid_cyc;
            r_hi = s - 1;
        end else begin
            b_hi = 1 << 30;
            r_hi = 1 << 30;
        end
        idx = 0;
        guard = 0;
        while (idx < n && guard < 1000) begin
            @(negedge clk);
            jis8_valid = rand_gap ? ($urandom_range(0, 2) != 0) : 1'b1;
            jis8_code = chars[idx];
            if (poke && idx == 0) begin
                start = 1'b1;
                text_len = 8'd50;
            end
            acc = jis8_valid && jis8_ready;
            @(posedge clk);
            #1;
            start = 1'b0;
            if (acc) begin
                h = cyc;
                idx++;
            end
            guard++;
        end
        jis8_valid = 1'b0;
        if (n > 0) begin
            chk("handshakes", 352'(idx), 352'(n));
            exp_valid_cyc = h + lat(n) - 1;
            b_hi = exp_valid_cyc;
            r_hi = h - 1;
        end
        while (cyc <= exp_valid_cyc + 1) @(negedge clk);
    endtask

    initial begin
        // reset values
        #1;
        chk("rst codeword", codeword, '0);
        chk("rst flags", 352'({en_text_valid, busy, len_err, jis8_ready}), 352'(4'b0000));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;

        // reset mid-DATA: len 5, two characters, then async abort
        mon_en = 1'b0;
        @(negedge clk);
        start = 1'b1;
        text_len = 8'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            jis8_valid = 1'b1;
            jis8_code = 8'h30 + 8'(i);
            @(posedge clk);
            #1;
        end
        jis8_valid = 1'b0;
        chk("busy before abort", 352'(busy), 352'(1'b1));
        #2 rst = 1'b1;
        #1;
        chk("abort codeword", codeword, '0);
        chk("abort flags", 352'({en_text_valid, busy, len_err, jis8_ready}), 352'(4'b0000));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_valid_cyc = -1;
        exp_lerr_cyc = -1;
        b_lo = 1;
        b_hi = 0;
        r_hi = 0;
        mon_en = 1'b1;
        repeat (3) @(negedge clk);

        // len 1, 'A'; a stray start during DATA must be ignored
        chars = '{8'h41};
        encode(1'b0, 1'b1);
        chk("len1 b0", 352'(cw_cap[7:0]), 352'(8'h40));
        chk("len1 b1", 352'(cw_cap[15:8]), 352'(8'h14));
        chk("len1 b2", 352'(cw_cap[23:16]), 352'(8'h10));
        if (PAD_EN) begin
            chk("len1 b3", 352'(cw_cap[31:24]), 352'(8'hEC));
            chk("len1 b4", 352'(cw_cap[39:32]), 352'(8'h11));
            chk("len1 b42", 352'(cw_cap[343:336]), 352'(8'h11));
            chk("len1 b43", 352'(cw_cap[351:344]), 352'(8'hEC));
        end else begin
            chk("len1 b3..43", 352'(cw_cap[351:24]), '0);
        end

        // len 0 with a valid character held on the bus that must be ignored
        jis8_valid = 1'b1;
        jis8_code = 8'hFF;
        chars = {};
        encode(1'b0, 1'b0);
        chk("len0 b0", 352'(cw_cap[7:0]), 352'(8'h40));
        chk("len0 b1", 352'(cw_cap[15:8]), 352'(8'h00));
        chk("len0 b2", 352'(cw_cap[23:16]), PAD_EN ? 352'(8'hEC) : 352'(8'h00));

        // len 3 mixed characters
        chars = '{8'hA5, 8'h0F, 8'hF0};
        encode(1'b1, 1'b0);
        chk("len3 decode", 352'(de_text_errs(cw_cap, chars)), '0);

        // len 42 = maximum, characters 0x00..0x29 with random gaps
        chars = {};
        for (int i = 0; i < 42; i++) chars.push_back(8'(i));
        encode(1'b1, 1'b0);
        chk("len42 b0", 352'(cw_cap[7:0]), 352'(8'h42));
        chk("len42 b1", 352'(cw_cap[15:8]), 352'(8'hA0));
        chk("len42 b43", 352'(cw_cap[351:344]), 352'(8'h90));
        chk("len42 decode", 352'(de_text_errs(cw_cap, chars)), '0);

        // len 43 is rejected; codeword must keep the len-42 result
        @(negedge clk);
        start = 1'b1;
        text_len = 8'd43;
        @(posedge clk);
        #1;
        start = 1'b0;
        exp_lerr_cyc = cyc;
        repeat (4) @(negedge clk);
        chk("len43 codeword kept", codeword, cw_cap);

        repeat (2) @(negedge clk);
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
